// File: rtl/mem_pkg.sv
// Shared types, constants and the simulator-side physical memory for mem_port.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef enum logic {
        CH_IF = 1'b0,
        CH_D  = 1'b1
    } mem_ch_e;

    localparam int          WORD_BYTES = 8;
    localparam logic [63:0] ALIGN_MASK = ~64'(WORD_BYTES - 1);

    // Simulator-side backing store standing in for the host pmem_read/pmem_write
    // entry points. The access counters and last read address let the simulation
    // environment observe exactly which calls the port made.
    logic [63:0] pmem_mem [logic [63:0]];
    int unsigned pmem_rd_cnt;
    int unsigned pmem_wr_cnt;
    logic [63:0] pmem_last_rd_addr;

    function automatic logic [63:0] pmem_read(input logic [63:0] addr);
        pmem_rd_cnt       = pmem_rd_cnt + 32'd1;
        pmem_last_rd_addr = addr;
        if (pmem_mem.exists(addr) != 0) begin
            return pmem_mem[addr];
        end else begin
            return 64'd0;
        end
    endfunction

    function automatic void pmem_write(input logic [63:0] addr,
                                       input logic [63:0] data,
                                       input logic [7:0]  mask);
        logic [63:0] word;
        word = (pmem_mem.exists(addr) != 0) ? pmem_mem[addr] : 64'd0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (mask[b]) begin
                word[8*b +: 8] = data[8*b +: 8];
            end
        end
        pmem_mem[addr] = word;
        pmem_wr_cnt    = pmem_wr_cnt + 32'd1;
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin grant between the IF and D request channels.
module mem_rr_arb
    import mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_idle,
    input  logic    i_if_valid,
    input  logic    i_d_valid,
    input  logic    i_accept,
    output mem_ch_e o_grant,
    output logic    o_if_ready,
    output logic    o_d_ready
);

    mem_ch_e r_ptr;
    mem_ch_e w_grant;

    // Pick the winner: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        w_grant = CH_IF;
        if (i_if_valid && i_d_valid) begin
            w_grant = r_ptr;
        end else if (i_d_valid) begin
            w_grant = CH_D;
        end else begin
            w_grant = CH_IF;
        end
    end

    // Only the granted channel sees ready, and only while the port is idle
    always_comb begin
        o_grant    = w_grant;
        o_if_ready = i_idle && i_if_valid && (w_grant == CH_IF);
        o_d_ready  = i_idle && i_d_valid  && (w_grant == CH_D);
    end

    // Pointer moves past the winner only when a contended request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= CH_IF;
        end else if (i_accept && i_if_valid && i_d_valid) begin
            r_ptr <= (r_ptr == CH_IF) ? CH_D : CH_IF;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/mem_port.sv
// Shares the simulator memory between the fetch and data channels, one access
// outstanding at a time, with a programmable access latency.
module mem_port
    import mem_pkg::*;
#(
    parameter int  ADDR_W  = 64,
    parameter int  DATA_W  = 64,
    parameter int  LATENCY = 1,
    localparam int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [7:0]        d_req_wmask,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [DATA_W-1:0] d_resp_rdata
);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("mem_port: LATENCY must be at least 1");
        end
        if (DATA_W != 64) begin : g_bad_width
            $error("mem_port: DATA_W must be 64");
        end
    endgenerate

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_live;
    mem_ch_e           w_grant;
    mem_ch_e           r_ch;
    logic              w_if_ready;
    logic              w_d_ready;
    logic              w_idle;
    logic              w_accept;
    logic              w_access;
    logic              w_resp_hs;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;
    logic [DATA_W-1:0] r_rdata;
    logic [63:0]       w_word_addr;

    // r_live keeps both readies low while reset is asserted, whatever the valids do
    assign w_idle      = r_live && (r_state == IDLE);
    assign w_accept    = (w_if_ready && if_req_valid) || (w_d_ready && d_req_valid);
    assign w_access    = (r_state == WAIT) && (r_cnt == {CNT_W{1'b0}});
    assign w_resp_hs   = (r_state == RESP) &&
                         ((r_ch == CH_IF) ? if_resp_ready : d_resp_ready);
    assign w_word_addr = 64'(r_addr) & ALIGN_MASK;

    mem_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_idle     (w_idle),
        .i_if_valid (if_req_valid),
        .i_d_valid  (d_req_valid),
        .i_accept   (w_accept),
        .o_grant    (w_grant),
        .o_if_ready (w_if_ready),
        .o_d_ready  (w_d_ready)
    );

    assign if_req_ready  = w_if_ready;
    assign d_req_ready   = w_d_ready;
    assign if_resp_valid = (r_state == RESP) && (r_ch == CH_IF);
    assign d_resp_valid  = (r_state == RESP) && (r_ch == CH_D);
    assign if_resp_data  = r_rdata;
    assign d_resp_rdata  = r_rdata;

    // Next-state and latency countdown: IDLE -> WAIT on accept, WAIT -> RESP at zero, RESP -> IDLE on handshake
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (w_resp_hs) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, countdown and the out-of-reset flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_live  <= 1'b1;
        end
    end

    // Capture the granted request, then perform the memory access when the countdown expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch    <= CH_IF;
            r_addr  <= {ADDR_W{1'b0}};
            r_we    <= 1'b0;
            r_wdata <= {DATA_W{1'b0}};
            r_wmask <= 8'h00;
            r_rdata <= {DATA_W{1'b0}};
        end else if (w_accept) begin
            r_ch    <= w_grant;
            r_addr  <= (w_grant == CH_D) ? d_req_addr : if_req_addr;
            r_we    <= (w_grant == CH_D) && d_req_we;
            r_wdata <= d_req_wdata;
            r_wmask <= d_req_wmask;
        end else if (w_access) begin
            if (r_we) begin
                if (r_wmask != 8'h00) begin
                    pmem_write(w_word_addr, r_wdata, r_wmask);
                end
                r_rdata <= {DATA_W{1'b0}};
            end else begin
                r_rdata <= pmem_read(w_word_addr);
            end
        end
    end

endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Successor to the combinational DPI memory read block. Shares one DPI-backed physical memory between an instruction-fetch (IF) channel and a data (D) channel.
- Each channel has a valid/ready request and a valid/ready response. The two channels are round-robin arbitrated, with one access outstanding at a time.
- Read/write latency is programmable; writes use a byte mask.
- Sits between the core's fetch/LSU stages and the simulator's pmem_read/pmem_write.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, data width; must equal 64 (DPI longint)
- LATENCY, 1, cycles from request accept to response valid; must be >= 1 (elaboration error otherwise)
- CNT_W, $clog2(LATENCY+1), latency counter width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  ADDR_W  IF byte address
- if_resp_valid  out  1  IF read data valid
- if_resp_ready  in  1  IF consumer ready
- if_resp_data  out  DATA_W  aligned 64-bit word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted
- d_req_addr  in  ADDR_W  byte address
- d_req_we  in  1  1 = write, 0 = read
- d_req_wdata  in  DATA_W  write data, aligned lanes
- d_req_wmask  in  8  byte strobes
- d_resp_valid  out  1  data response valid (reads and writes)
- d_resp_ready  in  1  consumer ready
- d_resp_rdata  out  DATA_W  read data; 0 for writes

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all req_ready and resp_valid = 0; resp data = 0.
  - Round-robin pointer = IF. Latched request cleared. No DPI call.
- FSM states:
  - IDLE: arbitrate.
  - WAIT: latency countdown.
  - RESP: hold response.
- IDLE grant:
  - Only one valid: that channel is granted.
  - Both valid: the pointer's channel is granted, and the pointer flips to the other channel on the handshake.
  - Single-channel grants leave the pointer unchanged.
  - req_ready = (state==IDLE) & grant for that channel. It may depend combinationally on the valids; the ungranted channel sees ready=0.
- Accept (valid&ready at edge N):
  - Latch channel id, addr, we, wdata, wmask. IF requests are always reads.
  - Go to WAIT with cnt=LATENCY-1.
- WAIT:
  - cnt!=0: decrement.
  - cnt==0: perform the DPI access at that edge (edge N+LATENCY) and go to RESP.
  - Read: pmem_read(addr & ~7, data) into the response register.
  - Write: pmem_write(addr & ~7, wdata, wmask) only when wmask!=0; response data = 0.
- RESP:
  - The latched channel's resp_valid = 1; data held stable until resp_ready.
  - On handshake, go to IDLE at the next edge. No request is accepted in WAIT or RESP.
  - Minimum occupancy is LATENCY+2 cycles per access.
- Addresses: low 3 bits are ignored for the access and carry no error. Data is the full aligned word; sub-word extraction is the LSU's job.
- Data/mask written while the channel is not granted is ignored.
- Mid-operation reset: the pending transaction is dropped, no DPI call is made afterwards, and outputs return to reset values immediately.
- resp_valid never asserts on the non-owning channel. Both resp_valids are never high together.

Decomposition:
- Package mem_pkg holds:
  - DPI imports pmem_read/pmem_write
  - typedef enum mem_state_e {IDLE, WAIT, RESP}
  - typedef enum mem_ch_e {CH_IF, CH_D}
  - constants WORD_BYTES=8, ALIGN_MASK
- Sub-module mem_rr_arb: 2-way round-robin grant, holding the pointer flop. Inputs: valids and accept; outputs: grant and the one-hot readies.

Test Plan:
- Reset mid-WAIT: LATENCY=4, D read accepted, rst_n=0 two cycles later -> all outputs 0 asynchronously; no pmem_read logged; after release, if_req_ready=1 when if_req_valid=1.
- IF read, LATENCY=3, mem[0x80000000]=0x0000001300000297, if_req_addr=0x80000004 -> pmem_read addr=0x80000000; if_resp_valid rises exactly 3 edges after accept; data=0x0000001300000297.
- D write addr 0x80000100, wdata=0x1122334455667788, wmask=0x0F over word 0xAAAAAAAAAAAAAAAA, then read -> d_resp_rdata=0xAAAAAAAA55667788; write response data=0.
- Both valid from reset -> IF granted first (d_req_ready=0), D next. A second simultaneous pair -> D first, then IF.
- Backpressure: d_resp_ready=0 for 5 cycles -> d_resp_valid and data stable, both req_ready=0; ready=1 -> IDLE next edge, new request accepted.
- D write with wmask=0x00 -> no pmem_write call; d_resp_valid after LATENCY; rdata=0.
